bram_copy_engine: RTL and testbench

- Memory-to-memory copy initiator that drives both ports of the dual-port `bram` as the master side.
- Reads a block through BRAM port B and writes it through port A, pipelined at one word per clock.
- Used for bulk moves inside data memory: relocating a loaded image, clearing-by-copy, stack and frame copies.
- Host control is a simple start/busy/done handshake with optional abort.

---
 rtl/bram_copy_engine.sv | 128 ++++++++++++
 tb/tb_bram_copy_engine.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_copy_engine.sv
// Block copy initiator for a dual-port synchronous-read BRAM: reads through port B,
// writes through port A one clock later, sustaining one word per clock.
module bram_copy_engine #(
   parameter int P_DATA_WIDTH    = 16,
   parameter int P_ADDRESS_WIDTH = 10
) (
   input  logic                       I_CLK,
   input  logic                       I_NRESET,
   input  logic                       I_START,
   input  logic                       I_ABORT,
   input  logic [P_ADDRESS_WIDTH-1:0] I_SRC_ADDRESS,
   input  logic [P_ADDRESS_WIDTH-1:0] I_DST_ADDRESS,
   input  logic [P_ADDRESS_WIDTH:0]   I_LENGTH,
   output logic                       O_BUSY,
   output logic                       O_DONE,
   output logic [P_ADDRESS_WIDTH:0]   O_COUNT,
   output logic [P_ADDRESS_WIDTH-1:0] O_MEM_ADDRESS_A,
   output logic [P_DATA_WIDTH-1:0]    O_MEM_DATA_A,
   output logic                       O_MEM_WRITE_ENABLE_A,
   output logic [P_ADDRESS_WIDTH-1:0] O_MEM_ADDRESS_B,
   output logic                       O_MEM_WRITE_ENABLE_B,
   input  logic [P_DATA_WIDTH-1:0]    I_MEM_DATA_B
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [P_ADDRESS_WIDTH:0] LEFT_LAST = {{P_ADDRESS_WIDTH{1'b0}}, 1'b1};

   state_t                     state;
   logic [P_ADDRESS_WIDTH-1:0] rd_addr;
   logic [P_ADDRESS_WIDTH-1:0] wr_addr;
   logic [P_ADDRESS_WIDTH:0]   rd_left;
   logic [P_ADDRESS_WIDTH:0]   count;
   logic                       rd_valid;
   logic                       busy;
   logic                       done;

   // NOTE: all state updates use non-blocking assignments so every register in this
   // block samples the pre-edge values of its neighbours, independent of statement order.
   always_ff @(posedge I_CLK or negedge I_NRESET) begin
      if (!I_NRESET) begin
         state    <= S_IDLE;
         rd_addr  <= '0;
         wr_addr  <= '0;
         rd_left  <= '0;
         count    <= '0;
         rd_valid <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;

         // Write stage runs in any state; the pointer stays on the final write address.
         if (rd_valid) begin
            count <= count + 1'b1;
            if (state == S_READ && !I_ABORT) begin
               wr_addr <= wr_addr + 1'b1;
            end
         end

         case (state)
            S_IDLE: begin
               if (I_START) begin
                  count <= '0;
                  if (I_LENGTH != '0) begin
                     rd_addr <= I_SRC_ADDRESS;
                     wr_addr <= I_DST_ADDRESS;
                     rd_left <= I_LENGTH;
                     busy    <= 1'b1;
                     state   <= S_READ;
                  end else begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end
               end
            end

            S_READ: begin
               if (I_ABORT) begin
                  rd_valid <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= S_DONE;
               end else begin
                  rd_valid <= 1'b1;
                  rd_left  <= rd_left - 1'b1;
                  if (rd_left == LEFT_LAST) begin
                     state <= S_DRAIN;
                  end else begin
                     rd_addr <= rd_addr + 1'b1;
                  end
               end
            end

            S_DRAIN: begin
               rd_valid <= 1'b0;
               busy     <= 1'b0;
               done     <= 1'b1;
               state    <= S_DONE;
            end

            S_DONE: begin
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Read data flows straight to port A so a word is written the cycle it arrives.
   assign O_MEM_DATA_A         = I_MEM_DATA_B;
   assign O_MEM_WRITE_ENABLE_A = rd_valid;
   assign O_MEM_ADDRESS_A      = wr_addr;
   assign O_MEM_ADDRESS_B      = rd_addr;
   assign O_MEM_WRITE_ENABLE_B = 1'b0;
   assign O_BUSY               = busy;
   assign O_DONE               = done;
   assign O_COUNT              = count;

endmodule

// File: tb/tb_bram_copy_engine.sv
// Self-checking bench for bram_copy_engine: behavioural BRAM, shadow memory model and a
// write scoreboard filled when each copy is launched.
module tb_bram_copy_engine;

   localparam int DW    = 16;
   localparam int AW    = 10;
   localparam int DEPTH = 1 << AW;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   logic          clk;
   logic          nreset;
   logic          start;
   logic          abort;
   logic [AW-1:0] src;
   logic [AW-1:0] dst;
   logic [AW:0]   len;
   logic          busy;
   logic          done;
   logic [AW:0]   count;
   logic [AW-1:0] addr_a;
   logic [DW-1:0] data_a;
   logic          we_a;
   logic [AW-1:0] addr_b;
   logic          we_b;
   logic [DW-1:0] rd_data;

   logic          pl_we;
   logic [AW-1:0] pl_addr;
   logic [DW-1:0] pl_data;

   logic [DW-1:0] mem   [DEPTH];
   logic [DW-1:0] model [DEPTH];
   wr_t           exp_q [$];

   int checks = 0;
   int errors = 0;

   bram_copy_engine #(.P_DATA_WIDTH(DW), .P_ADDRESS_WIDTH(AW)) dut (
      .I_CLK               (clk),
      .I_NRESET            (nreset),
      .I_START             (start),
      .I_ABORT             (abort),
      .I_SRC_ADDRESS       (src),
      .I_DST_ADDRESS       (dst),
      .I_LENGTH            (len),
      .O_BUSY              (busy),
      .O_DONE              (done),
      .O_COUNT             (count),
      .O_MEM_ADDRESS_A     (addr_a),
      .O_MEM_DATA_A        (data_a),
      .O_MEM_WRITE_ENABLE_A(we_a),
      .O_MEM_ADDRESS_B     (addr_b),
      .O_MEM_WRITE_ENABLE_B(we_b),
      .I_MEM_DATA_B        (rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Dual-port synchronous-read BRAM; the preload port borrows port A while the engine idles.
   always @(posedge clk) begin
      if (pl_we) mem[pl_addr] <= pl_data;
      else if (we_a) mem[addr_a] <= data_a;
      rd_data <= mem[addr_b];
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   function automatic logic [DW-1:0] preload_value(input int i);
      logic [DW-1:0] v;
      v = DW'(i * 16'h0123) ^ 16'h5A5A;
      if (i < 8) v = DW'(i + 1);
      if (i == 1022) v = 16'hAAAA;
      if (i == 1023) v = 16'hBBBB;
      return v;
   endfunction

   task automatic preload_all();
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         pl_we   = 1'b1;
         pl_addr = AW'(i);
         pl_data = preload_value(i);
         model[i] = preload_value(i);
      end
      @(negedge clk);
      pl_we = 1'b0;
   endtask

   task automatic check_image(input string tag);
      int nbad = 0;
      for (int i = 0; i < DEPTH; i++) begin
         if (mem[i] !== model[i]) nbad++;
      end
      check(tag, nbad, 0);
   endtask

   // Launches one copy and checks busy/done/write-enable every cycle against the
   // expected window; abort_at/restart_at/reset_at are cycle numbers (0 = unused).
   task automatic run_copy(input string name, input int s, input int d, input int l,
                           input int abort_at, input int restart_at, input int reset_at);
      int  e;
      int  nw;
      int  last;
      wr_t w;
      wr_t got;
      if (l == 0) e = 0;
      else if (reset_at > 0) e = reset_at - 1;
      else if (abort_at > 0) e = abort_at;
      else e = l + 1;
      nw = (e >= 2) ? e - 1 : 0;
      for (int i = 0; i < nw; i++) begin
         w.addr = AW'(d + i);
         w.data = model[AW'(s + i)];
         exp_q.push_back(w);
         model[w.addr] = w.data;
      end

      @(negedge clk);
      start = 1'b1;
      src   = AW'(s);
      dst   = AW'(d);
      len   = (AW + 1)'(l);
      @(posedge clk);
      #1;
      start = 1'b0;

      last = (reset_at > 0) ? reset_at + 1 : e + 2;
      for (int c = 1; c <= last; c++) begin
         if (c == abort_at) abort = 1'b1;
         if (c == restart_at) begin
            start = 1'b1;
            src   = 10'd200;
            dst   = 10'd300;
            len   = 11'd5;
         end
         if (c == reset_at) begin
            #1;
            nreset = 1'b0;
            #1;
            check({name, "_rst_we_a"}, we_a, 0);
            check({name, "_rst_busy"}, busy, 0);
            check({name, "_rst_count"}, count, 0);
         end
         @(negedge clk);
         check({name, "_busy"}, busy, (c >= 1 && c <= e));
         check({name, "_done"}, done, (reset_at == 0 && c == e + 1));
         check({name, "_we_a"}, we_a, (c >= 2 && c <= e));
         check({name, "_we_b"}, we_b, 0);
         if (we_a) begin
            if (exp_q.size() == 0) begin
               check({name, "_unexpected_write"}, 1, 0);
            end else begin
               got = exp_q.pop_front();
               check({name, "_wr_addr"}, addr_a, got.addr);
               check({name, "_wr_data"}, data_a, got.data);
            end
         end
         @(posedge clk);
         #1;
         abort = 1'b0;
         start = 1'b0;
      end

      check({name, "_count"}, count, (reset_at > 0) ? 0 : nw);
      check({name, "_pending_writes"}, exp_q.size(), 0);
      if (reset_at > 0) begin
         @(negedge clk);
         nreset = 1'b1;
         repeat (2) @(posedge clk);
      end
      check_image({name, "_image"});
   endtask

   initial begin
      nreset  = 1'b0;
      start   = 1'b0;
      abort   = 1'b0;
      src     = '0;
      dst     = '0;
      len     = '0;
      pl_we   = 1'b0;
      pl_addr = '0;
      pl_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_we_a", we_a, 0);
      check("reset_we_b", we_b, 0);
      check("reset_count", count, 0);
      check("reset_addr_a", addr_a, 0);
      check("reset_addr_b", addr_b, 0);
      nreset = 1'b1;
      repeat (2) @(posedge clk);

      preload_all();

      run_copy("basic", 0, 16, 8, 0, 0, 0);
      for (int i = 0; i < 8; i++) check("basic_readback", mem[16 + i], i + 1);

      run_copy("zero_len", 5, 500, 0, 0, 0, 0);

      run_copy("wrap", 1022, 100, 4, 0, 0, 0);
      check("wrap_100", mem[100], 16'hAAAA);
      check("wrap_101", mem[101], 16'hBBBB);
      check("wrap_102", mem[102], 16'h0001);
      check("wrap_103", mem[103], 16'h0002);

      run_copy("abort", 0, 32, 8, 4, 0, 0);
      for (int i = 0; i < 3; i++) check("abort_readback", mem[32 + i], i + 1);
      check("abort_untouched_35", mem[35], preload_value(35));

      run_copy("busy_start", 0, 48, 8, 0, 3, 0);
      for (int i = 0; i < 8; i++) check("busy_start_readback", mem[48 + i], i + 1);

      run_copy("reset_mid", 0, 64, 8, 0, 0, 5);
      check("reset_mid_untouched_67", mem[67], preload_value(67));

      run_copy("after_reset", 0, 80, 8, 0, 0, 0);
      for (int i = 0; i < 8; i++) check("after_reset_readback", mem[80 + i], i + 1);

      run_copy("full_mem", 0, 0, DEPTH, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
